// File: rtl/fetch_sequencer_pkg.sv
// Shared types and constants for the instruction-fetch sequencer.
package fetch_sequencer_pkg;

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2
    } fetch_state_t;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] ALIGN_MASK       = 32'hFFFF_FFFC;

    function automatic logic [31:0] align_pc(input logic [31:0] pc);
        return pc & ALIGN_MASK;
    endfunction

endpackage

// File: rtl/fetch_perf_counter.sv
// Saturating event counter; holds at all-ones instead of wrapping.
module fetch_perf_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             inc_i,
    output logic [CNT_W-1:0] count_o
);

    logic [CNT_W-1:0] count_q;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            count_q <= '0;
        end else if (inc_i && (count_q != {CNT_W{1'b1}})) begin
            count_q <= count_q + 1'b1;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller: owns the fetch PC, runs one imem transaction
// at a time, drops responses made stale by redirects, holds one instruction for decode.
//
// state  | meaning
// S_REQ  | request driven at pc, waiting for gnt
// S_WAIT | request accepted, waiting for rvalid (kill_q marks it stale)
// S_HOLD | instruction held for decode, if_valid high
module fetch_sequencer
    import fetch_sequencer_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int          CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             redirect_valid,
    input  logic [31:0]      redirect_pc,
    output logic             imem_req,
    output logic [31:0]      imem_addr,
    input  logic             imem_gnt,
    input  logic             imem_rvalid,
    input  logic [31:0]      imem_rdata,
    output logic             if_valid,
    input  logic             if_ready,
    output logic [31:0]      if_instr,
    output logic [31:0]      if_pc,
    output logic [31:0]      if_pc_plus4,
    output logic [CNT_W-1:0] fetch_count,
    output logic [CNT_W-1:0] kill_count
);

    fetch_state_t state_q;
    logic [31:0]  pc_q;
    logic [31:0]  req_pc_q;
    logic         kill_q;
    logic         imem_req_q;
    logic         if_valid_q;
    logic [31:0]  if_instr_q;
    logic [31:0]  if_pc_q;
    logic [31:0]  if_pc_plus4_q;
    logic [31:0]  target;
    logic         fetch_inc;
    logic         kill_inc;

    assign target = align_pc(redirect_pc);

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q       <= S_REQ;
            pc_q          <= RESET_PC;
            req_pc_q      <= RESET_PC;
            kill_q        <= 1'b0;
            imem_req_q    <= 1'b1;
            if_valid_q    <= 1'b0;
            if_instr_q    <= 32'h0;
            if_pc_q       <= 32'h0;
            if_pc_plus4_q <= 32'd4;
        end else begin
            case (state_q)
                S_REQ: begin
                    if (redirect_valid) pc_q <= target;
                    if (imem_gnt) begin
                        if (redirect_valid) begin
                            kill_q <= 1'b1;
                        end else begin
                            req_pc_q <= pc_q;
                            pc_q     <= pc_q + 32'd4;
                        end
                        state_q    <= S_WAIT;
                        imem_req_q <= 1'b0;
                    end
                end
                S_WAIT: begin
                    if (imem_rvalid) begin
                        if (kill_q || redirect_valid) begin
                            kill_q <= 1'b0;
                            if (redirect_valid) pc_q <= target;
                            state_q    <= S_REQ;
                            imem_req_q <= 1'b1;
                        end else begin
                            if_instr_q    <= imem_rdata;
                            if_pc_q       <= req_pc_q;
                            if_pc_plus4_q <= req_pc_q + 32'd4;
                            state_q       <= S_HOLD;
                            if_valid_q    <= 1'b1;
                        end
                    end else if (redirect_valid) begin
                        // Only one response is ever owed, so a single kill bit suffices.
                        kill_q <= 1'b1;
                        pc_q   <= target;
                    end
                end
                S_HOLD: begin
                    if (redirect_valid || if_ready) begin
                        if (redirect_valid) pc_q <= target;
                        state_q    <= S_REQ;
                        if_valid_q <= 1'b0;
                        imem_req_q <= 1'b1;
                    end
                end
                default: begin
                    state_q    <= S_REQ;
                    if_valid_q <= 1'b0;
                    imem_req_q <= 1'b1;
                end
            endcase
        end
    end

    assign fetch_inc = (state_q == S_HOLD) && if_ready && !redirect_valid;
    assign kill_inc  = (state_q == S_WAIT) && imem_rvalid && (kill_q || redirect_valid);

    fetch_perf_counter #(.CNT_W(CNT_W)) u_fetch_cnt (
        .clk     (clk),
        .rstn    (rstn),
        .inc_i   (fetch_inc),
        .count_o (fetch_count)
    );

    fetch_perf_counter #(.CNT_W(CNT_W)) u_kill_cnt (
        .clk     (clk),
        .rstn    (rstn),
        .inc_i   (kill_inc),
        .count_o (kill_count)
    );

    assign imem_req    = imem_req_q;
    assign imem_addr   = pc_q;
    assign if_valid    = if_valid_q;
    assign if_instr    = if_instr_q;
    assign if_pc       = if_pc_q;
    assign if_pc_plus4 = if_pc_plus4_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer with a one-outstanding imem model.
module tb_fetch_sequencer;

    logic        clk = 1'b0;
    logic        rstn;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic [31:0] if_pc_plus4;
    logic [31:0] fetch_count;
    logic [31:0] kill_count;

    logic        s_req, s_valid;
    logic [31:0] s_addr, s_instr, s_pc, s_pc4;
    logic [1:0]  s_fetch, s_kill;

    logic        gnt_en, rv_en;
    logic        pend;
    logic [31:0] pend_addr;
    logic [31:0] last_grant_addr;
    int          grant_cnt;
    int          n_checks = 0;
    int          n_pass   = 0;
    int          g0;

    always #5 clk = ~clk;

    fetch_sequencer dut (
        .clk(clk), .rstn(rstn),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .if_valid(if_valid), .if_ready(if_ready), .if_instr(if_instr),
        .if_pc(if_pc), .if_pc_plus4(if_pc_plus4),
        .fetch_count(fetch_count), .kill_count(kill_count)
    );

    // Narrow-counter copy fed the same stimulus, to reach saturation quickly.
    fetch_sequencer #(.CNT_W(2)) dut_sat (
        .clk(clk), .rstn(rstn),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_req(s_req), .imem_addr(s_addr),
        .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .if_valid(s_valid), .if_ready(if_ready), .if_instr(s_instr),
        .if_pc(s_pc), .if_pc_plus4(s_pc4),
        .fetch_count(s_fetch), .kill_count(s_kill)
    );

    always @(posedge clk) begin
        if (!rstn) begin
            pend <= 1'b0;
        end else if (imem_gnt) begin
            pend            <= 1'b1;
            pend_addr       <= imem_addr;
            last_grant_addr <= imem_addr;
            grant_cnt       <= grant_cnt + 1;
        end else if (imem_rvalid) begin
            pend <= 1'b0;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic drive_mem();
        imem_gnt    = gnt_en & imem_req;
        imem_rvalid = rv_en & pend;
        imem_rdata  = imem_rvalid ? (pend_addr ^ 32'h0050_0093) : 32'h0;
    endtask

    task automatic tick();
        drive_mem();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        rstn = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
        if_ready = 1'b1; gnt_en = 1'b1; rv_en = 1'b1;
        grant_cnt = 0; last_grant_addr = 32'h0; pend_addr = 32'h0;
        imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0;
        @(negedge clk);
        tick(); tick();
        rstn = 1'b1;

        check("rst_valid", {31'h0, if_valid}, 32'h0);
        check("rst_req", {31'h0, imem_req}, 32'h1);
        check("rst_addr", imem_addr, 32'h0);
        check("rst_pc", if_pc, 32'h0);
        check("rst_instr", if_instr, 32'h0);
        check("rst_pc4", if_pc_plus4, 32'h4);
        check("rst_fcnt", fetch_count, 32'h0);
        check("rst_kcnt", kill_count, 32'h0);

        // Back-to-back fetches: REQ, WAIT, HOLD per instruction.
        for (int c = 0; c < 9; c++) begin
            check("t1_req", {31'h0, imem_req}, {31'h0, (c % 3) == 0});
            check("t1_valid", {31'h0, if_valid}, {31'h0, (c % 3) == 2});
            if ((c % 3) == 0) check("t1_addr", imem_addr, 32'(4 * (c / 3)));
            if ((c % 3) == 2) check("t1_ifpc", if_pc, 32'(4 * (c / 3)));
            if (c == 2) begin
                check("t1_pc4", if_pc_plus4, 32'h4);
                check("t1_instr", if_instr, 32'h0050_0093);
            end
            tick();
        end
        check("t1_fcnt", fetch_count, 32'd3);
        check("t1_next_addr", imem_addr, 32'hC);

        // Redirect while waiting: response arrives later and is dropped.
        rv_en = 1'b0;
        tick();
        redirect_valid = 1'b1; redirect_pc = 32'h103;
        tick();
        redirect_valid = 1'b0;
        check("t2_wait_req", {31'h0, imem_req}, 32'h0);
        rv_en = 1'b1;
        tick();
        check("t2_valid", {31'h0, if_valid}, 32'h0);
        check("t2_kcnt", kill_count, 32'd1);
        check("t2_fcnt", fetch_count, 32'd3);
        check("t2_addr", imem_addr, 32'h100);
        check("t2_req", {31'h0, imem_req}, 32'h1);

        tick(); tick();
        check("t3_pc100", if_pc, 32'h100);
        check("t3_instr100", if_instr, 32'h0050_0193);
        tick();
        check("t3_addr104", imem_addr, 32'h104);
        // Redirect coincident with gnt.
        redirect_valid = 1'b1; redirect_pc = 32'h200;
        tick();
        redirect_valid = 1'b0;
        tick();
        check("t3_kcnt", kill_count, 32'd2);
        check("t3_valid", {31'h0, if_valid}, 32'h0);
        check("t3_addr", imem_addr, 32'h200);
        tick(); tick();
        check("t3_hold", {31'h0, if_valid}, 32'h1);
        check("t3_ifpc", if_pc, 32'h200);
        check("t3_pc4", if_pc_plus4, 32'h204);
        check("t3_instr", if_instr, 32'h0050_0293);
        check("t3_fcnt", fetch_count, 32'd4);
        check("sat_fcnt", {30'h0, s_fetch}, 32'd3);

        // Decode stalls, then a redirect flushes the held instruction.
        if_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            check("t4_valid", {31'h0, if_valid}, 32'h1);
            check("t4_pc", if_pc, 32'h200);
            check("t4_instr", if_instr, 32'h0050_0293);
            check("t4_req", {31'h0, imem_req}, 32'h0);
            if (k == 2) begin
                redirect_valid = 1'b1; redirect_pc = 32'h303;
            end
            tick();
        end
        redirect_valid = 1'b0;
        check("t4_flush", {31'h0, if_valid}, 32'h0);
        check("t4_fcnt", fetch_count, 32'd4);
        check("t4_addr", imem_addr, 32'h300);
        check("t4_req_after", {31'h0, imem_req}, 32'h1);

        // Grant withheld, redirect mid-way; only the target gets granted.
        gnt_en = 1'b0;
        g0 = grant_cnt;
        tick();
        redirect_valid = 1'b1; redirect_pc = 32'h40;
        tick();
        redirect_valid = 1'b0;
        check("t5_addr", imem_addr, 32'h40);
        tick(); tick();
        check("t5_addr_hold", imem_addr, 32'h40);
        check("t5_req", {31'h0, imem_req}, 32'h1);
        gnt_en = 1'b1;
        tick();
        check("t5_grants", 32'(grant_cnt - g0), 32'd1);
        check("t5_gaddr", last_grant_addr, 32'h40);
        check("t5_req_off", {31'h0, imem_req}, 32'h0);
        tick();
        check("t5_ifpc", if_pc, 32'h40);
        check("t5_hold", {31'h0, if_valid}, 32'h1);

        // Reset while holding.
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        check("t6_valid", {31'h0, if_valid}, 32'h0);
        check("t6_fcnt", fetch_count, 32'h0);
        check("t6_kcnt", kill_count, 32'h0);
        check("t6_req", {31'h0, imem_req}, 32'h1);
        check("t6_addr", imem_addr, 32'h0);
        check("t6_pc4", if_pc_plus4, 32'h4);

        // PC wrap at the top of the address space.
        gnt_en = 1'b0;
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFF;
        tick();
        redirect_valid = 1'b0;
        check("t7_addr", imem_addr, 32'hFFFF_FFFC);
        gnt_en = 1'b1; if_ready = 1'b1;
        tick(); tick();
        check("t7_ifpc", if_pc, 32'hFFFF_FFFC);
        check("t7_pc4", if_pc_plus4, 32'h0);
        check("t7_instr", if_instr, 32'hFFAF_FF6F);
        tick();
        check("t7_wrap", imem_addr, 32'h0);
        check("t7_fcnt", fetch_count, 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
